// File: rtl/gem_sched_pkg.sv
// rtl/gem_sched_pkg.sv - shared widths, state encoding and slot record types for the GEM cluster scheduler
package gem_sched_pkg;

  localparam int NSLOTS   = 8;
  localparam int SLOTBITS = 3;
  localparam int ROLLBITS = 3;
  localparam int PADBITS  = 8;
  localparam int SIZEBITS = 3;
  localparam int WIREBITS = 6;
  localparam int HSBITS   = 8;

  localparam logic [ROLLBITS-1:0] ME1A_ROLL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic                vpf;
    logic [ROLLBITS-1:0] roll;
    logic [PADBITS-1:0]  pad;
    logic [SIZEBITS-1:0] size;
  } cluster_t;

  typedef struct packed {
    logic                vpf;
    logic                me1a;
    logic [WIREBITS-1:0] wire_lo;
    logic [WIREBITS-1:0] wire_hi;
    logic [HSBITS-1:0]   hs_lo;
    logic [HSBITS-1:0]   hs_hi;
  } result_t;

  // Invalid clusters produce an all-zero record regardless of what the lane returned.
  function automatic result_t make_result(
    input cluster_t            c,
    input logic [WIREBITS-1:0] wire_lo,
    input logic [WIREBITS-1:0] wire_hi,
    input logic [HSBITS-1:0]   me1b_lo,
    input logic [HSBITS-1:0]   me1b_hi,
    input logic [HSBITS-1:0]   me1a_lo,
    input logic [HSBITS-1:0]   me1a_hi
  );
    result_t r;
    r = '0;
    if (c.vpf) begin
      r.vpf     = 1'b1;
      r.me1a    = (c.roll == ME1A_ROLL);
      r.wire_lo = wire_lo;
      r.wire_hi = wire_hi;
      r.hs_lo   = r.me1a ? me1a_lo : me1b_lo;
      r.hs_hi   = r.me1a ? me1a_hi : me1b_hi;
    end
    return r;
  endfunction

endpackage

// File: rtl/gem_cluster_pick2.sv
// rtl/gem_cluster_pick2.sv - combinational pick of the two lowest set bits of a slot mask
module gem_cluster_pick2
  import gem_sched_pkg::*;
(
  input  logic [NSLOTS-1:0]   mask,
  output logic                pick0_valid,
  output logic [SLOTBITS-1:0] pick0_idx,
  output logic                pick1_valid,
  output logic [SLOTBITS-1:0] pick1_idx
);

  // Scanning downward, each hit pushes the previous best into pick1.
  always_comb begin
    pick0_valid = 1'b0;
    pick0_idx   = '0;
    pick1_valid = 1'b0;
    pick1_idx   = '0;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        pick1_valid = pick0_valid;
        pick1_idx   = pick0_idx;
        pick0_valid = 1'b1;
        pick0_idx   = SLOTBITS'(i);
      end
    end
  end

endmodule

// File: rtl/gem_cluster_xlate_sched.sv
// rtl/gem_cluster_xlate_sched.sv - sequences one frame of 8 GEM clusters through two translator lanes
// GEM_SCHED_SKIP_INVALID_EN: issue only valid slots instead of all eight in fixed pairs.
module gem_cluster_xlate_sched
  import gem_sched_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_valid,
  input  logic [NSLOTS-1:0]        cl_vpf,
  input  logic [NSLOTS*ROLLBITS-1:0] cl_roll,
  input  logic [NSLOTS*PADBITS-1:0]  cl_pad,
  input  logic [NSLOTS*SIZEBITS-1:0] cl_size,
  output logic                     lane0_vpf,
  output logic [ROLLBITS-1:0]      lane0_roll,
  output logic [PADBITS-1:0]       lane0_pad,
  output logic [SIZEBITS-1:0]      lane0_size,
  output logic                     lane1_vpf,
  output logic [ROLLBITS-1:0]      lane1_roll,
  output logic [PADBITS-1:0]       lane1_pad,
  output logic [SIZEBITS-1:0]      lane1_size,
  input  logic [WIREBITS-1:0]      lane0_wire_lo,
  input  logic [WIREBITS-1:0]      lane0_wire_hi,
  input  logic [HSBITS-1:0]        lane0_me1bhs_lo,
  input  logic [HSBITS-1:0]        lane0_me1bhs_hi,
  input  logic [HSBITS-1:0]        lane0_me1ahs_lo,
  input  logic [HSBITS-1:0]        lane0_me1ahs_hi,
  input  logic [WIREBITS-1:0]      lane1_wire_lo,
  input  logic [WIREBITS-1:0]      lane1_wire_hi,
  input  logic [HSBITS-1:0]        lane1_me1bhs_lo,
  input  logic [HSBITS-1:0]        lane1_me1bhs_hi,
  input  logic [HSBITS-1:0]        lane1_me1ahs_lo,
  input  logic [HSBITS-1:0]        lane1_me1ahs_hi,
  output logic [NSLOTS-1:0]        res_vpf,
  output logic [NSLOTS-1:0]        res_me1a,
  output logic [NSLOTS*WIREBITS-1:0] res_wire_lo,
  output logic [NSLOTS*WIREBITS-1:0] res_wire_hi,
  output logic [NSLOTS*HSBITS-1:0]   res_hs_lo,
  output logic [NSLOTS*HSBITS-1:0]   res_hs_hi,
  output logic                     busy,
  output logic                     done,
  output logic                     frame_drop,
  output logic [7:0]               drop_count
);

  logic [1:0]          state;
  cluster_t            frame_q [NSLOTS];
  result_t             res_q   [NSLOTS];
  logic [NSLOTS-1:0]   pending;
  logic                tag0_v, tag1_v;
  logic [SLOTBITS-1:0] tag0_slot, tag1_slot;

  logic                p0_v, p1_v;
  logic [SLOTBITS-1:0] p0_idx, p1_idx;
  logic                issue0, issue1;
  cluster_t            lane0_c, lane1_c;
  logic [NSLOTS-1:0]   pick_mask, next_pending, accept_pending;
  result_t             cap0, cap1;

  gem_cluster_pick2 u_pick (
    .mask        (pending),
    .pick0_valid (p0_v),
    .pick0_idx   (p0_idx),
    .pick1_valid (p1_v),
    .pick1_idx   (p1_idx)
  );

`ifdef GEM_SCHED_SKIP_INVALID_EN
  assign accept_pending = cl_vpf;
`else
  assign accept_pending = '1;
`endif

  assign issue0 = (state == ST_ISSUE) && p0_v;
  assign issue1 = (state == ST_ISSUE) && p1_v;

  always_comb begin
    lane0_c   = issue0 ? frame_q[p0_idx] : '0;
    lane1_c   = issue1 ? frame_q[p1_idx] : '0;
    pick_mask = '0;
    if (issue0) pick_mask[p0_idx] = 1'b1;
    if (issue1) pick_mask[p1_idx] = 1'b1;
  end

  assign next_pending = pending & ~pick_mask;

  assign lane0_vpf  = lane0_c.vpf;
  assign lane0_roll = lane0_c.roll;
  assign lane0_pad  = lane0_c.pad;
  assign lane0_size = lane0_c.size;
  assign lane1_vpf  = lane1_c.vpf;
  assign lane1_roll = lane1_c.roll;
  assign lane1_pad  = lane1_c.pad;
  assign lane1_size = lane1_c.size;

  // Lane outputs in this cycle belong to the slots tagged on the previous issue.
  always_comb begin
    cap0 = make_result(frame_q[tag0_slot], lane0_wire_lo, lane0_wire_hi,
                       lane0_me1bhs_lo, lane0_me1bhs_hi, lane0_me1ahs_lo, lane0_me1ahs_hi);
    cap1 = make_result(frame_q[tag1_slot], lane1_wire_lo, lane1_wire_hi,
                       lane1_me1bhs_lo, lane1_me1bhs_hi, lane1_me1ahs_lo, lane1_me1ahs_hi);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      pending    <= '0;
      tag0_v     <= 1'b0;
      tag1_v     <= 1'b0;
      tag0_slot  <= '0;
      tag1_slot  <= '0;
      frame_drop <= 1'b0;
      drop_count <= '0;
      for (int i = 0; i < NSLOTS; i++) begin
        frame_q[i] <= '0;
        res_q[i]   <= '0;
      end
    end else begin
      frame_drop <= frame_valid && (state != ST_IDLE);
      if (frame_valid && (state != ST_IDLE) && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
      tag0_v    <= issue0;
      tag1_v    <= issue1;
      tag0_slot <= p0_idx;
      tag1_slot <= p1_idx;
      if (tag0_v) res_q[tag0_slot] <= cap0;
      if (tag1_v) res_q[tag1_slot] <= cap1;
      case (state)
        ST_IDLE: begin
          if (frame_valid) begin
            for (int i = 0; i < NSLOTS; i++) begin
              frame_q[i] <= {cl_vpf[i], cl_roll[i*ROLLBITS +: ROLLBITS],
                             cl_pad[i*PADBITS +: PADBITS], cl_size[i*SIZEBITS +: SIZEBITS]};
              res_q[i]   <= '0;
            end
            pending <= accept_pending;
            state   <= (accept_pending == '0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          pending <= next_pending;
          if (next_pending == '0) state <= ST_DRAIN;
        end
        ST_DRAIN: state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    res_vpf     = '0;
    res_me1a    = '0;
    res_wire_lo = '0;
    res_wire_hi = '0;
    res_hs_lo   = '0;
    res_hs_hi   = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      res_vpf[i]                         = res_q[i].vpf;
      res_me1a[i]                        = res_q[i].me1a;
      res_wire_lo[i*WIREBITS +: WIREBITS] = res_q[i].wire_lo;
      res_wire_hi[i*WIREBITS +: WIREBITS] = res_q[i].wire_hi;
      res_hs_lo[i*HSBITS +: HSBITS]       = res_q[i].hs_lo;
      res_hs_hi[i*HSBITS +: HSBITS]       = res_q[i].hs_hi;
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_gem_cluster_xlate_sched.sv
// tb/tb_gem_cluster_xlate_sched.sv - directed table-driven bench for gem_cluster_xlate_sched
module tb_gem_cluster_xlate_sched;

  logic        clock, reset, frame_valid;
  logic [7:0]  cl_vpf;
  logic [23:0] cl_roll, cl_size;
  logic [63:0] cl_pad;
  logic        lane0_vpf, lane1_vpf;
  logic [2:0]  lane0_roll, lane1_roll, lane0_size, lane1_size;
  logic [7:0]  lane0_pad, lane1_pad;
  logic [5:0]  lane0_wire_lo, lane0_wire_hi, lane1_wire_lo, lane1_wire_hi;
  logic [7:0]  lane0_me1bhs_lo, lane0_me1bhs_hi, lane0_me1ahs_lo, lane0_me1ahs_hi;
  logic [7:0]  lane1_me1bhs_lo, lane1_me1bhs_hi, lane1_me1ahs_lo, lane1_me1ahs_hi;
  logic [7:0]  res_vpf, res_me1a;
  logic [47:0] res_wire_lo, res_wire_hi;
  logic [63:0] res_hs_lo, res_hs_hi;
  logic        busy, done, frame_drop;
  logic [7:0]  drop_count;

  gem_cluster_xlate_sched dut (
    .clock(clock), .reset(reset), .frame_valid(frame_valid),
    .cl_vpf(cl_vpf), .cl_roll(cl_roll), .cl_pad(cl_pad), .cl_size(cl_size),
    .lane0_vpf(lane0_vpf), .lane0_roll(lane0_roll), .lane0_pad(lane0_pad), .lane0_size(lane0_size),
    .lane1_vpf(lane1_vpf), .lane1_roll(lane1_roll), .lane1_pad(lane1_pad), .lane1_size(lane1_size),
    .lane0_wire_lo(lane0_wire_lo), .lane0_wire_hi(lane0_wire_hi),
    .lane0_me1bhs_lo(lane0_me1bhs_lo), .lane0_me1bhs_hi(lane0_me1bhs_hi),
    .lane0_me1ahs_lo(lane0_me1ahs_lo), .lane0_me1ahs_hi(lane0_me1ahs_hi),
    .lane1_wire_lo(lane1_wire_lo), .lane1_wire_hi(lane1_wire_hi),
    .lane1_me1bhs_lo(lane1_me1bhs_lo), .lane1_me1bhs_hi(lane1_me1bhs_hi),
    .lane1_me1ahs_lo(lane1_me1ahs_lo), .lane1_me1ahs_hi(lane1_me1ahs_hi),
    .res_vpf(res_vpf), .res_me1a(res_me1a),
    .res_wire_lo(res_wire_lo), .res_wire_hi(res_wire_hi),
    .res_hs_lo(res_hs_lo), .res_hs_hi(res_hs_hi),
    .busy(busy), .done(done), .frame_drop(frame_drop), .drop_count(drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Translator stand-in with one cycle of latency.
  logic [2:0] l0_roll_q, l0_size_q, l1_roll_q, l1_size_q;
  logic [7:0] l0_pad_q, l1_pad_q;
  always_ff @(posedge clock) begin
    l0_roll_q <= lane0_roll; l0_size_q <= lane0_size; l0_pad_q <= lane0_pad;
    l1_roll_q <= lane1_roll; l1_size_q <= lane1_size; l1_pad_q <= lane1_pad;
  end
  assign lane0_wire_lo   = l0_pad_q[5:0];
  assign lane0_wire_hi   = {l0_size_q, l0_roll_q};
  assign lane0_me1bhs_lo = l0_pad_q * 8'd10;
  assign lane0_me1bhs_hi = l0_pad_q ^ 8'h0F;
  assign lane0_me1ahs_lo = l0_pad_q + 8'd100;
  assign lane0_me1ahs_hi = ~l0_pad_q;
  assign lane1_wire_lo   = l1_pad_q[5:0];
  assign lane1_wire_hi   = {l1_size_q, l1_roll_q};
  assign lane1_me1bhs_lo = l1_pad_q * 8'd10;
  assign lane1_me1bhs_hi = l1_pad_q ^ 8'h0F;
  assign lane1_me1ahs_lo = l1_pad_q + 8'd100;
  assign lane1_me1ahs_hi = ~l1_pad_q;

  typedef struct {
    logic [7:0]  vpf;
    logic [23:0] roll;
    logic [63:0] pad;
    logic [23:0] size;
    logic [7:0]  exp_me1a;
    int          lat_fixed;
    int          lat_skip;
  } vec_t;

  vec_t vecs [5];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive_garbage();
    cl_vpf  = 8'($urandom());
    cl_roll = 24'($urandom());
    cl_pad  = {$urandom(), $urandom()};
    cl_size = 24'($urandom());
  endtask

  task automatic check_results(input vec_t v, input string tag);
    logic [47:0] e_wlo, e_whi;
    logic [63:0] e_hlo, e_hhi;
    logic [7:0]  p;
    logic [2:0]  r, s;
    e_wlo = '0; e_whi = '0; e_hlo = '0; e_hhi = '0;
    for (int i = 0; i < 8; i++) begin
      if (v.vpf[i]) begin
        p = v.pad[i*8 +: 8];
        r = v.roll[i*3 +: 3];
        s = v.size[i*3 +: 3];
        e_wlo[i*6 +: 6] = p[5:0];
        e_whi[i*6 +: 6] = {s, r};
        e_hlo[i*8 +: 8] = (r == 3'd7) ? p + 8'd100 : p * 8'd10;
        e_hhi[i*8 +: 8] = (r == 3'd7) ? ~p : p ^ 8'h0F;
      end
    end
    check({tag, " res_vpf"},     64'(res_vpf),     64'(v.vpf));
    check({tag, " res_me1a"},    64'(res_me1a),    64'(v.exp_me1a));
    check({tag, " res_wire_lo"}, 64'(res_wire_lo), 64'(e_wlo));
    check({tag, " res_wire_hi"}, 64'(res_wire_hi), 64'(e_whi));
    check({tag, " res_hs_lo"},   res_hs_lo,        e_hlo);
    check({tag, " res_hs_hi"},   res_hs_hi,        e_hhi);
  endtask

  task automatic present(input vec_t v);
    @(negedge clock);
    cl_vpf = v.vpf; cl_roll = v.roll; cl_pad = v.pad; cl_size = v.size;
    frame_valid = 1'b1;
  endtask

  task automatic run_frame(input vec_t v, output int lat, output int lanes);
    present(v);
    @(negedge clock);
    frame_valid = 1'b0;
    drive_garbage();
    lat   = 1;
    lanes = int'(lane0_vpf) + int'(lane1_vpf);
    while (!done && lat < 20) begin
      @(negedge clock);
      lat++;
      lanes += int'(lane0_vpf) + int'(lane1_vpf);
    end
  endtask

  function automatic int exp_lat(input vec_t v);
`ifdef GEM_SCHED_SKIP_INVALID_EN
    return v.lat_skip;
`else
    return v.lat_fixed;
`endif
  endfunction

  initial begin
    int lat, lanes, cnt, done_seen;

    vecs[0] = '{8'hFF, 24'hFAC688, 64'h0706050403020100, 24'h053977, 8'h80, 6, 6};
    vecs[1] = '{8'h84, 24'hFFFEFF, 64'h7565554535251505, 24'h5A5A5A, 8'h80, 6, 3};
    vecs[2] = '{8'h00, 24'hFFFFFF, 64'hFFFFFFFFFFFFFFFF, 24'hFFFFFF, 8'h00, 6, 1};
    vecs[3] = '{8'h55, 24'hFFFFFF, 64'h0123456789ABCDEF, 24'h123456, 8'h55, 6, 4};
    vecs[4] = '{8'h01, 24'h000000, 64'h00000000000000C3, 24'h000005, 8'h00, 6, 3};

    reset = 1'b1; frame_valid = 1'b0;
    cl_vpf = '0; cl_roll = '0; cl_pad = '0; cl_size = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset busy",       64'(busy),       64'd0);
    check("reset done",       64'(done),       64'd0);
    check("reset frame_drop", 64'(frame_drop), 64'd0);
    check("reset drop_count", 64'(drop_count), 64'd0);
    check("reset res_vpf",    64'(res_vpf),    64'd0);
    check("reset res_hs_lo",  res_hs_lo,       64'd0);
    check("reset lane vpf",   64'({lane0_vpf, lane1_vpf}), 64'd0);

    for (int k = 0; k < 5; k++) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      run_frame(vecs[k], lat, lanes);
      check({tag, " latency"},    64'(lat),   64'(exp_lat(vecs[k])));
      check({tag, " lane issues"}, 64'(lanes), 64'($countones(vecs[k].vpf)));
      check_results(vecs[k], tag);
      @(negedge clock);
      check({tag, " idle after done"}, 64'(busy), 64'd0);
    end

    // Lane assignment of the first issue cycle for the sparse frame.
    present(vecs[1]);
    @(negedge clock);
    frame_valid = 1'b0;
    drive_garbage();
`ifdef GEM_SCHED_SKIP_INVALID_EN
    check("pair lane0", 64'({lane0_vpf, lane0_roll, lane0_pad}), 64'({1'b1, 3'd3, 8'h25}));
    check("pair lane1", 64'({lane1_vpf, lane1_roll, lane1_pad}), 64'({1'b1, 3'd7, 8'h75}));
`else
    check("pair lane0", 64'({lane0_vpf, lane0_roll, lane0_pad}), 64'({1'b0, 3'd7, 8'h05}));
    check("pair lane1", 64'({lane1_vpf, lane1_roll, lane1_pad}), 64'({1'b0, 3'd7, 8'h15}));
`endif
    cnt = 1;
    while (!done && cnt < 20) begin @(negedge clock); cnt++; end
    check("pair latency", 64'(cnt), 64'(exp_lat(vecs[1])));
    @(negedge clock);

    // Overrun at T+2 and in the done cycle.
    present(vecs[0]);
    @(negedge clock);
    frame_valid = 1'b0;
    drive_garbage();
    @(negedge clock);
    frame_valid = 1'b1;
    @(negedge clock);
    frame_valid = 1'b0;
    check("overrun1 frame_drop", 64'(frame_drop), 64'd1);
    check("overrun1 busy",       64'(busy),       64'd1);
    cnt = 3;
    while (!done && cnt < 20) begin @(negedge clock); cnt++; end
    check("overrun latency", 64'(cnt), 64'(exp_lat(vecs[0])));
    frame_valid = 1'b1;
    drive_garbage();
    @(negedge clock);
    frame_valid = 1'b0;
    check("overrun2 frame_drop", 64'(frame_drop), 64'd1);
    check("overrun2 ignored",    64'(busy),       64'd0);
    check("overrun drop_count",  64'(drop_count), 64'd2);
    check_results(vecs[0], "overrun");
    @(negedge clock);
    check("overrun drop pulse end", 64'(frame_drop), 64'd0);

    // Reset in the middle of a frame.
    present(vecs[0]);
    @(negedge clock);
    frame_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset busy",        64'(busy),        64'd0);
    check("midreset res_vpf",     64'(res_vpf),     64'd0);
    check("midreset res_wire_lo", 64'(res_wire_lo), 64'd0);
    check("midreset res_hs_hi",   res_hs_hi,        64'd0);
    check("midreset drop_count",  64'(drop_count),  64'd0);
    done_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      done_seen += int'(done);
    end
    check("midreset no done", 64'(done_seen), 64'd0);
    run_frame(vecs[3], lat, lanes);
    check("post-reset latency", 64'(lat), 64'(exp_lat(vecs[3])));
    check_results(vecs[3], "post-reset");
    @(negedge clock);

    // Continuous frame_valid drives the drop counter into saturation.
    present(vecs[0]);
    repeat (700) @(negedge clock);
    frame_valid = 1'b0;
    @(negedge clock);
    check("saturated drop_count", 64'(drop_count), 64'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gem_cluster_xlate_sched.md
# gem_cluster_xlate_sched

Scheduler that sequences one BX frame of up to 8 GEM clusters through two shared `cluster_to_cscwirehalfstrip` translator lanes, which use dual-port LUT access. It issues at most two clusters per cycle and captures each lane's 1-cycle-latency result into a per-slot result bank. It then pulses `done` so downstream GEM–CSC matching can consume all 8 slot results together. It sits between the GEM cluster receiver and the matching logic.

## Interface
- `NSLOTS`, 8, clusters per frame (fixed; 3-bit slot index)
- `clock` in 1: sole clock
- `reset` in 1: synchronous, active-high
- `frame_valid` in 1: new frame present this cycle
- `cl_vpf` in 8: per-slot valid
- `cl_roll` in 24: 3 bits/slot
- `cl_pad` in 64: 8 bits/slot
- `cl_size` in 24: 3 bits/slot
- `lane{0,1}_vpf`/`_roll`/`_pad`/`_size` out 1/3/8/3: translator lane inputs
- `lane{0,1}_wire_lo`/`_wire_hi` in 6: translator wire window
- `lane{0,1}_me1bhs_lo`/`_hi`, `_me1ahs_lo`/`_hi` in 8: translator HS windows
- `res_vpf` out 8: slot result valid
- `res_me1a` out 8: slot is ME1a (roll==7)
- `res_wire_lo`, `res_wire_hi` out 48: 6 bits/slot
- `res_hs_lo`, `res_hs_hi` out 64: 8 bits/slot; the me1a or me1b window selected by `res_me1a`
- `busy` out 1: state != IDLE
- `done` out 1: 1-cycle pulse; results complete
- `frame_drop` out 1: 1-cycle pulse; frame rejected
- `drop_count` out 8: saturating count of rejected frames

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE + `frame_valid`:
  - latch all cl_* into the frame register and clear the result bank;
  - build the pending mask;
  - go to ISSUE, or go to DONE if nothing is pending (macro build only).
- ISSUE:
  - pick up to two pending slots per cycle; lower slot index goes to lane0;
  - drive lane_* from the frame register and record the slot index in a 1-deep tag pipe per lane;
  - clear the picked slots from pending;
  - an unused lane drives vpf=0 with all fields 0;
  - leave for DRAIN after the cycle that empties pending.
- Capture: in the cycle after issue, each tagged lane writes its results into its tagged slot:
  - wire_lo/hi;
  - hs_lo/hi = me1a pair if the latched roll==7, else me1b pair;
  - res_me1a and res_vpf from the latched cl_vpf.
- DRAIN: captures the last issue, then goes to DONE.
- DONE: `done`=1, then go to IDLE.
- Slots never issued keep res_* = 0.
- Overrun: `frame_valid` in any state other than IDLE:
  - frame ignored;
  - `frame_drop` pulses in the next cycle;
  - `drop_count` increments and saturates at 255.
- Results hold from `done` until the next accepted frame.

## Timing
- Translator contract: lane inputs presented in cycle k → translator outputs valid in k+1 → captured at the end of k+1.
- Without the macro (frame accepted in cycle T):
  - ISSUE T+1..T+4 (slot pairs 0/1, 2/3, 4/5, 6/7);
  - DRAIN T+5, `done` at T+6, IDLE at T+7;
  - next frame accepted at T+7 at the earliest.
- With the macro, for n valid slots:
  - ISSUE lasts ceil(n/2) cycles, then DRAIN, then DONE;
  - n=0: DONE at T+1.
- Reset values: all outputs 0, `drop_count`=0, state IDLE.
- Reset in any state: immediate return to IDLE with no `done`; the in-flight tag pipe is cleared and the result bank is zeroed.
- `frame_valid` in the `done` cycle is dropped; IDLE accepts in the following cycle.

## Configuration
- `GEM_SCHED_SKIP_INVALID_EN` defined:
  - pending = `cl_vpf`; only valid slots are issued, compacted by priority pick;
  - latency varies from 1 to 6 cycles.
- Not defined:
  - pending = 8'hFF; all slots are issued in fixed pairs;
  - invalid slots are issued with lane_vpf=0 and their results are written with res_vpf=0 and fields forced to 0;
  - latency is a fixed 6 cycles.

## Structure
- Package `gem_sched_pkg`:
  - `NSLOTS`, `ROLLBITS`=3, `PADBITS`=8, `SIZEBITS`=3, `WIREBITS`=6, `HSBITS`=8;
  - `ME1A_ROLL`=3'd7;
  - state enum;
  - `cluster_t`/`result_t` packed structs.
- Sub-module `gem_cluster_pick2`: combinational; 8-bit mask in → two one-hot/encoded picks with valid flags.

## Test plan
- Without the macro, frame with all 8 valid and lanes returning wire_lo=slot, hs_lo=slot*10 → `done` at T+6; res_wire_lo slot i = i; res_vpf=8'hFF.
- With the macro, cl_vpf=8'b1000_0100 → slots 2 and 7 issued together in T+1 on lane0/lane1; `done` at T+3; slot 7 res_me1a=1 if roll=7 and res_hs uses the me1a pair.
- With the macro, cl_vpf=0 → `done` at T+1; all res_* = 0; lanes never driven valid.
- `frame_valid` asserted at T+2 and at the `done` cycle → `frame_drop` pulses twice; `drop_count`=2; results unaffected.
- 300 overrun frames → `drop_count` saturates at 255.
- `reset` asserted at T+3 → next cycle busy=0 and res_*=0; no `done`; a new frame is accepted normally afterward.
